// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing defaults, derived constants and control-bundle type.
// Imported by the timing generator and its delay line.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync begins right after the front porch; the end is exclusive.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

  localparam int DEF_H_SYNC_START = sync_start(DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_H_SYNC_END   = sync_end(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int DEF_V_SYNC_START = sync_start(DEF_V_ACTIVE, DEF_V_FP);
  localparam int DEF_V_SYNC_END   = sync_end(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

  typedef struct packed {
    logic hs;     // active-low
    logic vs;     // active-low
    logic blank;  // active-high
  } ctrl_t;

  localparam int    CTRL_W    = $bits(ctrl_t);
  localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that aligns control bits with a downstream pipeline.
// DEPTH of 0 is a plain passthrough.
module vga_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_pass;
      assign unused_pass = &{1'b0, clk, rst_n};
      assign dout        = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: emits pixel coordinates, then re-aligns sync/blank
// with the pattern generator's registered colour before driving the DAC pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [CNT_W-1:0]   oVGA_X,
  output logic [CNT_W-1:0]   oVGA_Y,
  output logic               oRequest,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n,
  output logic               oVGA_SYNC_n,
  output logic               oVBlank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  ctrl_t            ctrl_raw;
  ctrl_t            ctrl_dly;

  // No handshakes anywhere: the raster free-runs from reset release and the
  // pattern generator must return colour exactly PIPE_DLY clocks after a coordinate.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign oRequest      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign oVGA_X        = oRequest ? h_cnt : '0;
  assign oVGA_Y        = oRequest ? v_cnt : '0;
  assign oVBlank_start = (h_cnt == '0) && (v_cnt == V_VIS);
  assign oVGA_SYNC_n   = 1'b0;

  assign ctrl_raw.hs    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign ctrl_raw.vs    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign ctrl_raw.blank = !oRequest;

  vga_delay_line #(
    .DEPTH    (PIPE_DLY),
    .WIDTH    (CTRL_W),
    .RESET_VAL(CTRL_IDLE)
  ) u_ctrl_dly (
    .clk  (iVGA_CLK),
    .rst_n(iRST_n),
    .din  (ctrl_raw),
    .dout (ctrl_dly)
  );

  // Colour is forced to black whenever the aligned blank is set, so stray
  // pattern-generator output in the porches never reaches the DAC.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_n <= 1'b0;
    end else begin
      oVGA_R       <= ctrl_dly.blank ? '0 : iRed;
      oVGA_G       <= ctrl_dly.blank ? '0 : iGreen;
      oVGA_B       <= ctrl_dly.blank ? '0 : iBlue;
      oVGA_HS      <= ctrl_dly.hs;
      oVGA_VS      <= ctrl_dly.vs;
      oVGA_BLANK_n <= !ctrl_dly.blank;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size 640x480 instance plus three reduced rasters
// with PIPE_DLY 0, 1 and 3, each checked against an independent raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_reset_ev;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : cfg
      localparam bit FULL = (gi == 0);
      localparam int HA   = FULL ? 640 : 8;
      localparam int HF   = FULL ? 16  : 2;
      localparam int HSY  = FULL ? 96  : 3;
      localparam int HB   = FULL ? 48  : 3;
      localparam int VA   = FULL ? 480 : 6;
      localparam int VF   = FULL ? 10  : 2;
      localparam int VSY  = 2;
      localparam int VB   = FULL ? 33  : 2;
      localparam int P    = (gi == 1) ? 0 : (gi == 3) ? 3 : 1;
      localparam int HT   = HA + HF + HSY + HB;
      localparam int VT   = VA + VF + VSY + VB;

      logic [9:0] red, green, blue;
      logic [9:0] x, y, col_r, col_g, col_b;
      logic       req, hs, vs, bn, sn, vbs;

      logic [32:0] exp_q[$];
      logic [29:0] hist[$];

      vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .PIPE_DLY(P)
      ) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iRed         (red),
        .iGreen       (green),
        .iBlue        (blue),
        .oVGA_X       (x),
        .oVGA_Y       (y),
        .oRequest     (req),
        .oVGA_R       (col_r),
        .oVGA_G       (col_g),
        .oVGA_B       (col_b),
        .oVGA_HS      (hs),
        .oVGA_VS      (vs),
        .oVGA_BLANK_n (bn),
        .oVGA_SYNC_n  (sn),
        .oVBlank_start(vbs)
      );

      // Stimulus + model: checks coordinates, pushes expected pin values, plays pattern generator.
      initial begin
        int         mh, mv;
        bit         need_prefill, mreq, hs_e, vs_e;
        logic [29:0] col_e;
        logic [29:0] f;
        mh = 0; mv = 0; need_prefill = 1'b1;
        red = '1; green = '1; blue = '1;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            exp_q.delete();
            hist.delete();
            mh = 0; mv = 0; need_prefill = 1'b1;
            red = '1; green = '1; blue = '1;
          end else begin
            if (need_prefill) begin
              for (int i = 0; i <= P; i++) exp_q.push_back({30'd0, 3'b110});
              need_prefill = 1'b0;
            end
            mreq = (mh < HA) && (mv < VA);
            check($sformatf("c%0d request", gi), req, mreq);
            check($sformatf("c%0d x", gi), x, mreq ? 10'(mh) : 10'd0);
            check($sformatf("c%0d y", gi), y, mreq ? 10'(mv) : 10'd0);
            check($sformatf("c%0d vblank_start", gi), vbs, (mh == 0) && (mv == VA));
            hs_e  = !((mh >= HA + HF) && (mh < HA + HF + HSY));
            vs_e  = !((mv >= VA + VF) && (mv < VA + VF + VSY));
            col_e = mreq ? {10'(mh), 10'(mv), ~10'(mh)} : 30'd0;
            exp_q.push_back({col_e, hs_e, vs_e, mreq});
            f = req ? {x, y, ~x} : '1;
            hist.push_back(f);
            if (hist.size() > P) {red, green, blue} = hist.pop_front();
            else {red, green, blue} = '1;
            if (mh == HT - 1) begin
              mh = 0;
              mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
              mh++;
            end
          end
        end
      end

      // Monitor: pops expected pin values and checks sync/blank run lengths.
      initial begin
        logic [32:0] e;
        int cyc, hs_low, hs_per, vs_low, vs_per, bn_cnt, vb_cnt;
        bit hs_p, vs_p, hs_seen, vs_seen, first_done;
        cyc = 0; hs_low = 0; hs_per = 0; vs_low = 0; vs_per = 0; bn_cnt = 0; vb_cnt = 0;
        hs_p = 1'b1; vs_p = 1'b1; hs_seen = 1'b0; vs_seen = 1'b0; first_done = 1'b0;
        forever begin
          @(negedge clk);
          #1;
          if (!rst_n) begin
            cyc = 0; hs_p = 1'b1; vs_p = 1'b1;
            hs_seen = 1'b0; vs_seen = 1'b0; first_done = 1'b0;
            bn_cnt = 0; vb_cnt = 0;
          end else begin
            if (exp_q.size() == 0) begin
              check($sformatf("c%0d queue_underflow", gi), 1, 0);
            end else begin
              e = exp_q.pop_front();
              check($sformatf("c%0d pin_r", gi), col_r, e[32:23]);
              check($sformatf("c%0d pin_g", gi), col_g, e[22:13]);
              check($sformatf("c%0d pin_b", gi), col_b, e[12:3]);
              check($sformatf("c%0d pin_hs", gi), hs, e[2]);
              check($sformatf("c%0d pin_vs", gi), vs, e[1]);
              check($sformatf("c%0d pin_blank_n", gi), bn, e[0]);
            end
            check($sformatf("c%0d sync_n", gi), sn, 1'b0);
            if (!hs && hs_p) begin
              if (!first_done) begin
                check($sformatf("c%0d first_hs_fall", gi), cyc, HA + HF + P + 1);
                first_done = 1'b1;
              end else begin
                check($sformatf("c%0d hs_period", gi), hs_per, HT);
              end
              hs_per = 0; hs_low = 0; hs_seen = 1'b1;
            end
            if (hs && !hs_p && hs_seen) check($sformatf("c%0d hs_width", gi), hs_low, HSY);
            hs_per++;
            if (!hs) hs_low++;
            if (!vs && vs_p) begin
              if (vs_seen) begin
                check($sformatf("c%0d vs_period", gi), vs_per, HT * VT);
                check($sformatf("c%0d blank_n_high_per_frame", gi), bn_cnt, HA * VA);
                check($sformatf("c%0d vblank_pulses_per_frame", gi), vb_cnt, 1);
              end
              vs_per = 0; vs_low = 0; bn_cnt = 0; vb_cnt = 0; vs_seen = 1'b1;
            end
            if (vs && !vs_p && vs_seen) check($sformatf("c%0d vs_width", gi), vs_low, VSY * HT);
            vs_per++;
            if (!vs) vs_low++;
            if (bn) bn_cnt++;
            if (vbs) vb_cnt++;
            hs_p = hs; vs_p = vs;
            cyc++;
          end
        end
      end

      // Reset values must appear asynchronously, without waiting for a clock edge.
      initial begin
        forever begin
          @(chk_reset_ev);
          check($sformatf("c%0d rst_x", gi), x, 10'd0);
          check($sformatf("c%0d rst_y", gi), y, 10'd0);
          check($sformatf("c%0d rst_request", gi), req, 1'b1);
          check($sformatf("c%0d rst_rgb", gi), {col_r, col_g, col_b}, 30'd0);
          check($sformatf("c%0d rst_hs", gi), hs, 1'b1);
          check($sformatf("c%0d rst_vs", gi), vs, 1'b1);
          check($sformatf("c%0d rst_blank_n", gi), bn, 1'b0);
          check($sformatf("c%0d rst_vblank_start", gi), vbs, 1'b0);
        end
      end
    end
  endgenerate

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    -> chk_reset_ev;
    #1;
    rst_n = 1'b1;
    // 2549 = 13 reduced frames + line 3, column 5: a mid-frame point for the small rasters.
    repeat (2549) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    -> chk_reset_ev;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (900) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
